// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for sub_bytes_seq: input side (round controller) and
// output side (ShiftRows). The flush line exists only when
// SUB_BYTES_SEQ_FLUSH_EN is defined.
interface sub_bytes_seq_if;
    logic           in_valid;
    logic           in_ready;
    logic [0:127]   data_in;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   data_out;
    logic           busy;
`ifdef SUB_BYTES_SEQ_FLUSH_EN
    logic           flush;

    modport slave  (input  in_valid, data_in, out_ready, flush,
                    output in_ready, out_valid, data_out, busy);
    modport master (output in_valid, data_in, out_ready, flush,
                    input  in_ready, out_valid, data_out, busy);
`else
    modport slave  (input  in_valid, data_in, out_ready,
                    output in_ready, out_valid, data_out, busy);
    modport master (output in_valid, data_in, out_ready,
                    input  in_ready, out_valid, data_out, busy);
`endif
endinterface

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes. SBOX_COUNT S-boxes are reused across the 16 state
// bytes, one group per cycle, starting at byte 0 (the MSB end).
// Optional synchronous abort input: define SUB_BYTES_SEQ_FLUSH_EN.

// One AES S-box: multiplicative inverse in GF(2^8), then the affine map.
module sub_box (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_a2, w_a3, w_a12, w_a15, w_a240, w_inv;

    // Inverse computed as a^254 (0 maps to 0 naturally).
    always_comb begin
        w_a2   = gf_mul(i_byte, i_byte);
        w_a3   = gf_mul(w_a2, i_byte);
        w_a12  = gf_mul(gf_mul(w_a3, w_a3), gf_mul(w_a3, w_a3));
        w_a15  = gf_mul(w_a12, w_a3);
        w_a240 = gf_mul(w_a15, w_a15);
        w_a240 = gf_mul(w_a240, w_a240);
        w_a240 = gf_mul(w_a240, w_a240);
        w_a240 = gf_mul(w_a240, w_a240);
        w_inv  = gf_mul(gf_mul(w_a240, w_a12), w_a2);
        o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module sub_bytes_seq #(
    parameter int SBOX_COUNT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    sub_bytes_seq_if.slave  bus
);
    localparam int NUM_STEPS = 16 / SBOX_COUNT;
    localparam int CW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    if (SBOX_COUNT != 1 && SBOX_COUNT != 2 && SBOX_COUNT != 4 &&
        SBOX_COUNT != 8 && SBOX_COUNT != 16) begin : g_bad_sbox_count
        $error("sub_bytes_seq: SBOX_COUNT must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         r_state, w_next;
    logic [CW-1:0]                  r_cnt;
    logic [0:127]                   r_work;
    logic                           w_last, w_load, w_in_ready, w_flush;
    logic [SBOX_COUNT-1:0][7:0]     w_sb_in, w_sb_out;

`ifdef SUB_BYTES_SEQ_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_last = (r_cnt == CW'(NUM_STEPS - 1));

    // Select the byte group addressed by the step counter.
    always_comb begin
        for (int j = 0; j < SBOX_COUNT; j++)
            w_sb_in[j] = r_work[(int'(r_cnt) * SBOX_COUNT + j) * 8 +: 8];
    end

    for (genvar j = 0; j < SBOX_COUNT; j++) begin : g_sbox
        sub_box u_sb (.i_byte(w_sb_in[j]), .o_byte(w_sb_out[j]));
    end

    // Next-state and handshake decode; flush overrides everything.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            IDLE: begin
                // Held low while in reset so in_ready only rises afterwards.
                w_in_ready = reset_n;
                if (bus.in_valid) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                // Result consumed and a new state accepted in the same cycle.
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        w_load = 1'b1;
                        w_next = RUN;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_flush) begin
            w_next     = IDLE;
            w_in_ready = 1'b0;
            w_load     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Work register and step counter: load on accept, substitute one group per RUN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (w_flush) begin
            r_cnt  <= '0;
        end else if (w_load) begin
            r_work <= bus.data_in;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            for (int j = 0; j < SBOX_COUNT; j++)
                r_work[(int'(r_cnt) * SBOX_COUNT + j) * 8 +: 8] <= w_sb_out[j];
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.data_out  = r_work;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench: three instances (SBOX_COUNT 1, 4, 16) share the input
// stream; the SBOX_COUNT=4 instance also carries the corner-case sequences.
module tb_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] din = '0;
    logic         ordy4 = 1'b1;
    logic         flush4 = 1'b0;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    sub_bytes_seq_if b1 ();
    sub_bytes_seq_if b4 ();
    sub_bytes_seq_if b16 ();

    assign b1.in_valid  = in_valid;
    assign b4.in_valid  = in_valid;
    assign b16.in_valid = in_valid;
    assign b1.data_in   = din;
    assign b4.data_in   = din;
    assign b16.data_in  = din;
    assign b1.out_ready  = 1'b1;
    assign b4.out_ready  = ordy4;
    assign b16.out_ready = 1'b1;
`ifdef SUB_BYTES_SEQ_FLUSH_EN
    assign b1.flush  = 1'b0;
    assign b4.flush  = flush4;
    assign b16.flush = 1'b0;
`endif

    sub_bytes_seq #(.SBOX_COUNT(1))  u1  (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
    sub_bytes_seq #(.SBOX_COUNT(4))  u4  (.clk(clk), .reset_n(reset_n), .bus(b4.slave));
    sub_bytes_seq #(.SBOX_COUNT(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16.slave));

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        logic [127:0] d1, d4, d16;
        int           l1, l4, l16;
        logic         stale;

        vecs[0] = '{"zeros", {16{8'h00}}, {16{8'h63}}};
        vecs[1] = '{"fips_ex", 128'h00112233_44556677_8899aabb_ccddeeff,
                               128'h638293c3_1bfc33f5_c4eeacea_4bc12816};
        vecs[2] = '{"ones", {16{8'hff}}, {16{8'h16}}};
        vecs[3] = '{"x53", {16{8'h53}}, {16{8'hed}}};
        vecs[4] = '{"round1", 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808,
                              128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
        vecs[5] = '{"x01", {16{8'h01}}, {16{8'h7c}}};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  b4.in_ready,  1'b0);
        chk("rst_out_valid", b4.out_valid, 1'b0);
        chk("rst_busy",      b4.busy,      1'b0);
        chk("rst_data_out",  b4.data_out,  '0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {b1.in_ready, b4.in_ready, b16.in_ready}, 3'b111);
        @(negedge clk);

        // Table-driven vectors, latency and data on all three widths
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1;
            din      = vecs[v].din;
            #1;
            chk({vecs[v].name, "_in_ready"}, {b1.in_ready, b4.in_ready, b16.in_ready}, 3'b111);
            @(negedge clk);
            in_valid = 1'b0;
            din      = '0;
            chk({vecs[v].name, "_accept_state"},
                {b1.busy, b4.busy, b16.busy, b1.out_valid, b4.out_valid, b16.out_valid}, 6'b111000);
            l1 = 0; l4 = 0; l16 = 0;
            d1 = 'x; d4 = 'x; d16 = 'x;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (l1 == 0 && b1.out_valid)   begin l1 = c;  d1 = b1.data_out;   end
                if (l4 == 0 && b4.out_valid)   begin l4 = c;  d4 = b4.data_out;   end
                if (l16 == 0 && b16.out_valid) begin l16 = c; d16 = b16.data_out; end
            end
            chk({vecs[v].name, "_lat1"},  l1,  16);
            chk({vecs[v].name, "_lat4"},  l4,  4);
            chk({vecs[v].name, "_lat16"}, l16, 1);
            chk({vecs[v].name, "_data1"},  d1,  vecs[v].dout);
            chk({vecs[v].name, "_data4"},  d4,  vecs[v].dout);
            chk({vecs[v].name, "_data16"}, d16, vecs[v].dout);
        end

        // Back-pressure then same-cycle consume/accept
        ordy4    = 1'b0;
        in_valid = 1'b1;
        din      = vecs[1].din;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_flags", {b4.out_valid, b4.in_ready, b4.busy}, 3'b101);
            chk("bp_data",  b4.data_out, vecs[1].dout);
            @(negedge clk);
        end
        ordy4    = 1'b1;
        in_valid = 1'b1;
        din      = {16{8'hff}};
        #1;
        chk("bp_same_cycle_ready", {b4.in_ready, b4.out_valid}, 2'b11);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_reaccept_run", {b4.out_valid, b4.busy}, 2'b01);
        repeat (3) @(negedge clk);
        chk("bp_not_early", b4.out_valid, 1'b0);
        @(negedge clk);
        chk("bp_next_valid", b4.out_valid, 1'b1);
        chk("bp_next_data",  b4.data_out, {16{8'h16}});
        repeat (20) @(negedge clk);

        // Reset asserted at RUN step 2
        in_valid = 1'b1;
        din      = vecs[4].din;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_flags", {b4.out_valid, b4.busy, b4.in_ready, b1.busy}, 4'b0000);
        chk("midrst_data",  b4.data_out, '0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midrst_release_ready", b4.in_ready, 1'b1);
        stale = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b1.out_valid || b4.out_valid || b16.out_valid) stale = 1'b1;
        end
        chk("midrst_no_stale", stale, 1'b0);

        // in_valid held through RUN with changing data
        in_valid = 1'b1;
        din      = vecs[4].din;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            din = {4{$urandom}};
            @(negedge clk);
        end
        in_valid = 1'b0;
        din      = '0;
        @(negedge clk);
        chk("hold_valid", b4.out_valid, 1'b1);
        chk("hold_data",  b4.data_out, vecs[4].dout);
        repeat (20) @(negedge clk);

`ifdef SUB_BYTES_SEQ_FLUSH_EN
        // Flush at RUN step 1, then a clean operation
        in_valid = 1'b1;
        din      = {16{8'h00}};
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush4 = 1'b1;
        #1;
        chk("flush_in_ready", b4.in_ready, 1'b0);
        @(negedge clk);
        flush4 = 1'b0;
        chk("flush_idle", {b4.busy, b4.out_valid, b4.in_ready}, 3'b001);
        stale = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (b4.out_valid) stale = 1'b1;
        end
        chk("flush_no_valid", stale, 1'b0);
        in_valid = 1'b1;
        din      = {16{8'h53}};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_after_valid", b4.out_valid, 1'b1);
        chk("flush_after_data",  b4.data_out, {16{8'hed}});
        repeat (20) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
